// File: rtl/prog_loader.sv
// Purpose: loads a length-prefixed little-endian byte stream into instruction memory as 32-bit word writes.
// Latency: a word is written one cycle after its 4th byte is taken; done follows two cycles after the last byte.
// Backpressure: rx_ready drops during each write cycle and after done/err; rx_valid gaps simply hold state.
module prog_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] len_acc;     // length field being assembled, LSB first
  logic [31:0] word_sr;     // payload bytes of the current word
  logic [31:0] ptr;         // byte address of the next word to write
  logic [31:0] remaining;   // payload bytes still to be written
  logic [1:0]  idx;         // byte position within the length field or word

  logic        take;
  logic [31:0] len_next;
  logic [31:0] word_next;
  logic [31:0] remaining_after;
  logic        len_bad;

  // Handshake and next-value views of the shift registers; each new byte enters at the top
  // so that after four bytes the first one sits in bits 7:0.
  assign take            = rx_valid && rx_ready;
  assign len_next        = {rx_data, len_acc[31:8]};
  assign word_next       = {rx_data, word_sr[31:8]};
  assign remaining_after = remaining - 32'd4;
  assign len_bad         = (len_next == 32'd0) ||
                           (len_next[1:0] != 2'b00) ||
                           (len_next > MEM_LIMIT);

  // Session FSM with all outputs registered alongside the state transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_acc   <= '0;
      word_sr   <= '0;
      ptr       <= '0;
      remaining <= '0;
      idx       <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN;
            rx_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            ptr       <= '0;
            remaining <= '0;
            idx       <= '0;
            len_acc   <= '0;
          end
        end

        S_LEN: begin
          if (take) begin
            len_acc <= len_next;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (len_bad) begin
                // A bad length ends the session before any write is issued.
                state    <= S_ERR;
                err      <= 1'b1;
                rx_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                state     <= S_DATA;
                remaining <= len_next;
              end
            end
          end
        end

        S_DATA: begin
          if (take) begin
            word_sr <= word_next;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              // Present the completed word next cycle and pause the stream for that cycle.
              state     <= S_WRITE;
              rx_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= word_next;
            end
          end
        end

        S_WRITE: begin
          ptr       <= ptr + 32'd4;
          remaining <= remaining_after;
          if (remaining_after == 32'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
